// File: rtl/imager_frame_gen_if.sv
// imager_frame_gen_if: config inputs and fv/lv/data pixel stream of the synthetic imager source.
interface imager_frame_gen_if #(parameter int DATA_WIDTH = 10);
    logic                  enable;
    logic [15:0]           cfg_rows;
    logic [15:0]           cfg_cols;
    logic [15:0]           cfg_fv_pre;
    logic [15:0]           cfg_hblank;
    logic [15:0]           cfg_fv_post;
    logic [15:0]           cfg_vblank;
    logic [1:0]            cfg_pattern;
    logic                  fv;
    logic                  lv;
    logic [DATA_WIDTH-1:0] data;
    logic [15:0]           num_rows;
    logic [15:0]           num_cols;
    logic [15:0]           frame_count;
    modport master (
        input  enable, cfg_rows, cfg_cols, cfg_fv_pre, cfg_hblank, cfg_fv_post, cfg_vblank, cfg_pattern,
        output fv, lv, data, num_rows, num_cols, frame_count
    );
    modport slave (
        output enable, cfg_rows, cfg_cols, cfg_fv_pre, cfg_hblank, cfg_fv_post, cfg_vblank, cfg_pattern,
        input  fv, lv, data, num_rows, num_cols, frame_count
    );
endinterface

// File: rtl/imager_frame_gen.sv
// imager_frame_gen: synthetic image-sensor timing and test-pattern source in the pixclk domain.
module imager_frame_gen #(
    parameter int DATA_WIDTH = 10
) (
    input logic              pixclk,
    input logic              resetb,
    imager_frame_gen_if.master fg
);
    typedef enum logic [2:0] {IDLE, FV_PRE, LINE, HBLANK, FV_POST, VBLANK} state_t;
    state_t                r_state, w_next;
    logic [15:0]           r_cnt, w_cnt, r_row, w_row;
    logic [15:0]           r_rows, r_cols, r_fv_pre, r_hblank, r_fv_post, r_vblank;
    logic [1:0]            r_pattern;
    logic                  r_fv, r_lv;
    logic [DATA_WIDTH-1:0] r_data;
    logic [15:0]           r_frame_count;
    logic                  w_start, w_latch, w_fv, w_lv;
    logic [7:0]            w_v;

    assign w_start = fg.enable && fg.cfg_rows != 16'd0 && fg.cfg_cols != 16'd0;
    assign w_fv    = r_state inside {FV_PRE, LINE, HBLANK, FV_POST};
    assign w_lv    = r_state == LINE;
    // In LINE the state counter doubles as the column index.
    assign w_v = r_pattern == 2'd0 ? r_cnt[7:0] :
                 r_pattern == 2'd1 ? r_row[7:0] :
                 r_pattern == 2'd2 ? {8{r_cnt[3] ^ r_row[3]}} :
                 r_row[7:0] + r_cnt[7:0] + r_frame_count[7:0];

    always_comb begin
        w_next  = r_state;
        w_cnt   = r_cnt + 16'd1;
        w_row   = r_row;
        w_latch = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt = '0;
                if (w_start) begin
                    w_next  = FV_PRE;
                    w_latch = 1'b1;
                    w_row   = '0;
                end
            end
            FV_PRE: if (r_cnt == r_fv_pre - 16'd1) begin
                w_next = LINE;
                w_cnt  = '0;
            end
            LINE: if (r_cnt == r_cols - 16'd1) begin
                w_cnt  = '0;
                w_next = r_row != r_rows - 16'd1 ? HBLANK : r_fv_post != 16'd0 ? FV_POST : VBLANK;
            end
            HBLANK: if (r_cnt == r_hblank - 16'd1) begin
                w_next = LINE;
                w_cnt  = '0;
                w_row  = r_row + 16'd1;
            end
            FV_POST: if (r_cnt == r_fv_post - 16'd1) begin
                w_next = VBLANK;
                w_cnt  = '0;
            end
            VBLANK: if (r_cnt == r_vblank - 16'd1) begin
                w_cnt   = '0;
                w_row   = '0;
                w_next  = w_start ? FV_PRE : IDLE;
                w_latch = w_start;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge pixclk) begin
        if (!resetb) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_row         <= '0;
            r_rows        <= '0;
            r_cols        <= '0;
            r_fv_pre      <= '0;
            r_hblank      <= '0;
            r_fv_post     <= '0;
            r_vblank      <= '0;
            r_pattern     <= '0;
            r_fv          <= 1'b0;
            r_lv          <= 1'b0;
            r_data        <= '0;
            r_frame_count <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_row   <= w_row;
            if (w_latch) begin
                r_rows    <= fg.cfg_rows;
                r_cols    <= fg.cfg_cols;
                r_fv_pre  <= fg.cfg_fv_pre < 16'd8 ? 16'd8 : fg.cfg_fv_pre;
                r_hblank  <= fg.cfg_hblank == 16'd0 ? 16'd1 : fg.cfg_hblank;
                r_fv_post <= fg.cfg_fv_post;
                r_vblank  <= fg.cfg_vblank == 16'd0 ? 16'd1 : fg.cfg_vblank;
                r_pattern <= fg.cfg_pattern;
            end
            r_fv   <= w_fv;
            r_lv   <= w_lv;
            r_data <= w_lv ? DATA_WIDTH'(w_v) << (DATA_WIDTH - 8) : '0;
            if (r_fv && !w_fv)
                r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign fg.fv          = r_fv;
    assign fg.lv          = r_lv;
    assign fg.data        = r_data;
    assign fg.num_rows    = r_rows;
    assign fg.num_cols    = r_cols;
    assign fg.frame_count = r_frame_count;
endmodule

// File: tb/tb_imager_frame_gen.sv
// tb_imager_frame_gen: directed checks of imager_frame_gen timing, patterns and config latching.
module tb_imager_frame_gen;
    logic pixclk = 1'b0;
    logic resetb = 1'b0;
    int   n_chk  = 0;
    int   n_err  = 0;
    int   line, col, bad, fv_cnt, hi_cnt;
    logic prev_lv;
    logic [31:0] p00, p08, p80, p88;

    imager_frame_gen_if #(.DATA_WIDTH(10)) fg();
    imager_frame_gen #(.DATA_WIDTH(10)) dut (.pixclk(pixclk), .resetb(resetb), .fg(fg));

    always #5 pixclk = ~pixclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixclk);
        #1;
    endtask

    task automatic set_cfg(input int rows, cols, pre, hb, post, vb, pat);
        fg.cfg_rows    = 16'(rows);
        fg.cfg_cols    = 16'(cols);
        fg.cfg_fv_pre  = 16'(pre);
        fg.cfg_hblank  = 16'(hb);
        fg.cfg_fv_post = 16'(post);
        fg.cfg_vblank  = 16'(vb);
        fg.cfg_pattern = 2'(pat);
    endtask

    task automatic wait_fv(input int max);
        for (int i = 0; i < max && !fg.fv; i++) tick();
        check("wait_fv", 32'(fg.fv), 32'd1);
    endtask

    task automatic wait_lv(input int max);
        for (int i = 0; i < max && !fg.lv; i++) tick();
        check("wait_lv", 32'(fg.lv), 32'd1);
    endtask

    // Expected {fv,lv,data} for the 2x4 basic frame, indexed from the cycle fv rises.
    function automatic logic [11:0] basic_exp(input int k);
        if (k < 8)   return {2'b10, 10'd0};
        if (k < 12)  return {2'b11, 10'((k - 8) * 4)};
        if (k == 12) return {2'b10, 10'd0};
        if (k < 17)  return {2'b11, 10'((k - 13) * 4)};
        return 12'd0;
    endfunction

    initial begin
        fg.enable = 1'b1;
        set_cfg(2, 4, 0, 0, 0, 0, 0);
        repeat (5) tick();
        check("rst_fv", 32'(fg.fv), 32'd0);
        check("rst_lv", 32'(fg.lv), 32'd0);
        check("rst_data", 32'(fg.data), 32'd0);
        check("rst_fc", 32'(fg.frame_count), 32'd0);
        check("rst_rows", 32'(fg.num_rows), 32'd0);
        resetb = 1'b1;
        tick();
        check("start_lag", 32'(fg.fv), 32'd0);
        tick();
        check("start_fv", 32'(fg.fv), 32'd1);
        fg.enable = 1'b0;
        for (int k = 0; k < 18; k++) begin
            check($sformatf("basic_%0d", k), 32'({fg.fv, fg.lv, fg.data}), 32'(basic_exp(k)));
            if (k == 17) check("basic_fc", 32'(fg.frame_count), 32'd1);
            tick();
        end
        check("basic_idle", 32'(fg.fv), 32'd0);
        check("basic_nrows", 32'(fg.num_rows), 32'd2);
        check("basic_ncols", 32'(fg.num_cols), 32'd4);

        set_cfg(16, 16, 0, 0, 0, 0, 2);
        fg.enable = 1'b1;
        wait_fv(10);
        fg.enable = 1'b0;
        line = -1; col = 0; bad = 0; prev_lv = 1'b0;
        p00 = '1; p08 = '1; p80 = '1; p88 = '1;
        for (int c = 0; c < 1000 && fg.fv; c++) begin
            if (fg.lv) begin
                if (!prev_lv) begin
                    if (line >= 0 && col != 16) bad++;
                    line++;
                    col = 0;
                end
                if (line == 0 && col == 0) p00 = 32'(fg.data);
                if (line == 0 && col == 8) p08 = 32'(fg.data);
                if (line == 8 && col == 0) p80 = 32'(fg.data);
                if (line == 8 && col == 8) p88 = 32'(fg.data);
                col++;
            end
            prev_lv = fg.lv;
            tick();
        end
        if (col != 16) bad++;
        check("cb_end", 32'(fg.fv), 32'd0);
        check("cb_lines", 32'(line + 1), 32'd16);
        check("cb_linelen", 32'(bad), 32'd0);
        check("cb_p00", p00, 32'h000);
        check("cb_p08", p08, 32'h3FC);
        check("cb_p80", p80, 32'h3FC);
        check("cb_p88", p88, 32'h000);
        check("cb_fc", 32'(fg.frame_count), 32'd2);

        set_cfg(2, 4, 0, 2, 2, 3, 0);
        fg.enable = 1'b1;
        wait_fv(20);
        line = -1; col = 0; bad = 0; prev_lv = 1'b0; fv_cnt = 0;
        for (int c = 0; c < 200 && fg.fv; c++) begin
            fv_cnt++;
            if (fg.lv) begin
                if (!prev_lv) begin
                    if (line >= 0 && col != 4) bad++;
                    line++;
                    col = 0;
                    if (line == 0) begin
                        fg.enable   = 1'b0;
                        fg.cfg_cols = 16'd6;
                    end
                end
                col++;
            end
            prev_lv = fg.lv;
            tick();
        end
        if (col != 4) bad++;
        check("mid_lines", 32'(line + 1), 32'd2);
        check("mid_linelen", 32'(bad), 32'd0);
        check("mid_fv_len", 32'(fv_cnt), 32'd20);
        hi_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (fg.fv) hi_cnt++;
            tick();
        end
        check("mid_idle", 32'(hi_cnt), 32'd0);
        check("mid_ncols", 32'(fg.num_cols), 32'd4);

        set_cfg(0, 2, 0, 0, 0, 0, 0);
        fg.enable = 1'b1;
        hi_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (fg.fv) hi_cnt++;
        end
        check("zero_dim", 32'(hi_cnt), 32'd0);
        fg.cfg_rows = 16'd1;
        tick();
        tick();
        check("zero_release", 32'(fg.fv), 32'd1);
        fg.enable = 1'b0;
        for (int c = 0; c < 50 && fg.fv; c++) tick();
        check("zero_done", 32'(fg.fv), 32'd0);

        resetb = 1'b0;
        tick();
        resetb = 1'b1;
        check("pat_fc0", 32'(fg.frame_count), 32'd0);
        set_cfg(1, 2, 0, 0, 0, 0, 3);
        fg.enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_lv(20);
            check($sformatf("pat_f%0d_p0", f), 32'(fg.data), 32'(f << 2));
            if (f == 2) begin
                resetb = 1'b0;
                tick();
                check("mrst_fv", 32'(fg.fv), 32'd0);
                check("mrst_lv", 32'(fg.lv), 32'd0);
                check("mrst_data", 32'(fg.data), 32'd0);
                check("mrst_fc", 32'(fg.frame_count), 32'd0);
            end else begin
                tick();
                check($sformatf("pat_f%0d_p1", f), 32'(fg.data), 32'((f + 1) << 2));
                check($sformatf("pat_f%0d_nc", f), 32'(fg.num_cols), 32'd2);
                tick();
            end
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
